// File: rtl/cnn_pkg.sv
// Shared CNN pipeline definitions: conv1 feature-map geometry, pixel vector type
// and the per-lane signed max used by the pooling stages.
package cnn_pkg;

   localparam int CNN_DW   = 16;
   localparam int C1_CH    = 6;
   localparam int C1_OUT_W = 24;
   localparam int C1_OUT_H = 24;

   typedef logic [C1_CH*CNN_DW-1:0] c1_pix_t;

   // Ties return a, so callers pass the earlier sample first.
   function automatic c1_pix_t lane_max_s(input c1_pix_t a, input c1_pix_t b);
      c1_pix_t r;
      for (int k = 0; k < C1_CH; k++) begin
         r[k*CNN_DW +: CNN_DW] =
            ($signed(b[k*CNN_DW +: CNN_DW]) > $signed(a[k*CNN_DW +: CNN_DW])) ?
            b[k*CNN_DW +: CNN_DW] : a[k*CNN_DW +: CNN_DW];
      end
      return r;
   endfunction

endpackage

// File: rtl/cnn_sync_fifo.sv
// Single-clock first-word-fall-through FIFO used at CNN stage boundaries.
// pop_data shows the head entry whenever the FIFO is not empty, zero otherwise.
module cnn_sync_fifo #(
   parameter int DATA_W = 96,
   parameter int DEPTH  = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [DATA_W-1:0]          push_data,
   input  logic                       pop,
   output logic [DATA_W-1:0]          pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count_q;
   logic              do_push;
   logic              do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign empty    = (count_q == '0);
   assign full     = (count_q == (AW+1)'(DEPTH));
   assign count    = count_q;
   assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/pool1_maxpool2x2.sv
// 2x2 stride-2 max pool between conv1 and conv2: raster-order input, pooled
// pixels buffered in a FWFT FIFO with valid/ready backpressure toward conv1.
module pool1_maxpool2x2
   import cnn_pkg::*;
#(
   parameter int CH         = C1_CH,
   parameter int DW         = CNN_DW,
   parameter int IN_W       = C1_OUT_W,
   parameter int IN_H       = C1_OUT_H,
   parameter int FIFO_DEPTH = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [CH*DW-1:0] din,
   input  logic            din_valid,
   output logic            din_ready,
   output logic [CH*DW-1:0] dout,
   output logic            dout_valid,
   input  logic            dout_ready,
   output logic            frame_done
);

   localparam int CW   = $clog2(IN_W);
   localparam int RW   = $clog2(IN_H);
   localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNTW:0] READY_MAX = (CNTW+1)'(FIFO_DEPTH - 2);

   logic [CW-1:0]    col_q;
   logic [RW-1:0]    row_q;
   logic [CH*DW-1:0] h_q;
   logic [CH*DW-1:0] pool_q;
   logic [CH*DW-1:0] hmax;
   logic [CH*DW-1:0] lb_rd;
   logic [CH*DW-1:0] pool_max;
   logic [CH*DW-1:0] linebuf_q [IN_W/2];
   logic [CW-2:0]    lb_idx;
   logic             pool_v;
   logic             frame_done_q;
   logic             accept;
   logic             col_odd;
   logic             row_odd;
   logic             last_col;
   logic             last_row;
   logic             win_done;

   logic [CNTW-1:0]  fifo_count;
   logic [CNTW:0]    occ_sum;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_push;
   logic             fifo_pop;

   assign accept   = din_valid & din_ready;
   assign col_odd  = col_q[0];
   assign row_odd  = row_q[0];
   assign last_col = (col_q == CW'(IN_W - 1));
   assign last_row = (row_q == RW'(IN_H - 1));
   assign lb_idx   = col_q[CW-1:1];
   assign win_done = accept & row_odd & col_odd;

   assign hmax     = lane_max_s(h_q, din);
   assign lb_rd    = linebuf_q[lb_idx];
   assign pool_max = lane_max_s(lb_rd, hmax);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q <= '0;
         row_q <= '0;
      end else if (accept) begin
         if (last_col) begin
            col_q <= '0;
            row_q <= last_row ? '0 : row_q + RW'(1);
         end else begin
            col_q <= col_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q <= '0;
      end else if (accept && !col_odd) begin
         h_q <= din;
      end
   end

   // Top-row horizontal maxima wait here until the matching bottom row arrives.
   always_ff @(posedge clk) begin
      if (accept && !row_odd && col_odd) begin
         linebuf_q[lb_idx] <= hmax;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pool_q       <= '0;
         pool_v       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         pool_v       <= win_done;
         frame_done_q <= accept & last_row & last_col;
         if (win_done) begin
            pool_q <= pool_max;
         end
      end
   end

   // Counting the in-flight pool register keeps one slot of slack, so a push never meets a full FIFO.
   assign occ_sum   = {1'b0, fifo_count} + {{CNTW{1'b0}}, pool_v};
   assign din_ready = (occ_sum <= READY_MAX);

   assign fifo_push  = pool_v & ~fifo_full;
   assign fifo_pop   = dout_valid & dout_ready;
   assign dout_valid = ~fifo_empty;
   assign frame_done = frame_done_q;

   cnn_sync_fifo #(
      .DATA_W (CH*DW),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (pool_q),
      .pop       (fifo_pop),
      .pop_data  (dout),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_pool1_maxpool2x2.sv
// Directed self-checking bench for pool1_maxpool2x2: ramp frames, signed compare,
// latency, backpressure, mid-frame reset and back-to-back frames with random gaps.
`timescale 1ns/1ps
module tb_pool1_maxpool2x2;

   localparam int CH   = 6;
   localparam int DW   = 16;
   localparam int W    = 24;
   localparam int H    = 24;
   localparam int NPX  = W*H;
   localparam int NOUT = (W/2)*(H/2);

   logic          clk        = 1'b0;
   logic          rst_n      = 1'b0;
   logic [95:0]   din        = '0;
   logic          din_valid  = 1'b0;
   logic          din_ready;
   logic [95:0]   dout;
   logic          dout_valid;
   logic          dout_ready = 1'b0;
   logic          frame_done;

   int            checks = 0;
   int            errors = 0;

   // Written only by the monitor below.
   int            acc_cnt = 0;
   int            fd_cnt  = 0;
   logic [95:0]   got_q [$];

   pool1_maxpool2x2 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Inputs change at negedge; sampling 2 ns later sees what the next posedge will capture.
   always begin
      @(negedge clk);
      #2;
      if (rst_n) begin
         if (din_valid && din_ready) acc_cnt++;
         if (dout_valid && dout_ready) got_q.push_back(dout);
         if (frame_done) fd_cnt++;
      end
   end

   function automatic logic [95:0] ramp_px(input int pos);
      logic [95:0] px;
      int r, c;
      r = pos / W;
      c = pos % W;
      for (int k = 0; k < CH; k++) px[k*DW +: DW] = 16'(r*W + c + k);
      return px;
   endfunction

   function automatic logic [95:0] exp_out(input int p);
      logic [95:0] px;
      int i, j;
      i = p / (W/2);
      j = p % (W/2);
      for (int k = 0; k < CH; k++) px[k*DW +: DW] = 16'((2*i+1)*W + 2*j + 1 + k);
      return px;
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      din_valid  = 1'b0;
      dout_ready = 1'b0;
      rst_n      = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic stream(input int start_pos, input int n_px, input int v_pct,
                         input int r_pct, input int budget, output bit timed_out);
      int base, cyc;
      base = acc_cnt;
      cyc = 0;
      timed_out = 1'b0;
      forever begin
         @(negedge clk);
         if (acc_cnt - base >= n_px) break;
         if (cyc >= budget) begin
            timed_out = 1'b1;
            break;
         end
         cyc++;
         din        = ramp_px((start_pos + acc_cnt - base) % NPX);
         din_valid  = (int'($urandom_range(99)) < v_pct);
         dout_ready = (int'($urandom_range(99)) < r_pct);
      end
      din_valid = 1'b0;
   endtask

   task automatic wait_outputs(input int target, input int budget, output bit timed_out);
      int cyc;
      cyc = 0;
      timed_out = 1'b0;
      while (got_q.size() < target) begin
         if (cyc >= budget) begin
            timed_out = 1'b1;
            break;
         end
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      din_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b expected 0", dout_valid); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
      checks++; if (dout !== 96'h0) begin errors++; $display("FAIL reset_dout: got %h expected 0", dout); end
      checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready: got %b expected 1", din_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_ramp_frame();
      int got0, fd0;
      bit to;
      apply_reset();
      got0 = got_q.size();
      fd0  = fd_cnt;
      stream(0, NPX, 100, 100, 2000, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL ramp_input_timeout: got %b expected 0", to); end
      dout_ready = 1'b1;
      wait_outputs(got0 + NOUT, 200, to);
      repeat (5) @(negedge clk);
      checks++; if (got_q.size() - got0 != NOUT) begin errors++; $display("FAIL ramp_count: got %0d expected %0d", got_q.size() - got0, NOUT); end
      for (int p = 0; p < NOUT && got0 + p < got_q.size(); p++) begin
         checks++;
         if (got_q[got0+p] !== exp_out(p)) begin
            errors++; $display("FAIL ramp_out[%0d]: got %h expected %h", p, got_q[got0+p], exp_out(p));
         end
      end
      checks++; if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL ramp_frame_done: got %0d expected 1", fd_cnt - fd0); end
      $display("test_ramp_frame done: %0d outputs", got_q.size() - got0);
   endtask

   task automatic test_signed_compare();
      shortint l0 [4] = '{-5, -5, -3, -5};
      shortint l1 [4] = '{-32768, 0, 1, 32767};
      shortint l2 [4] = '{3, -1, 2, 1};
      int got0, base, r, c, w;
      bit to;
      apply_reset();
      dout_ready = 1'b1;
      got0 = got_q.size();
      base = acc_cnt;
      for (int pos = 0; pos < 2*W; pos++) begin
         @(negedge clk);
         r = pos / W;
         c = pos % W;
         din = '0;
         if (c < 2) begin
            w = r*2 + c;
            din[0  +: 16] = l0[w];
            din[16 +: 16] = l1[w];
            din[32 +: 16] = l2[w];
         end
         din_valid = 1'b1;
      end
      @(negedge clk);
      din_valid = 1'b0;
      wait_outputs(got0 + W/2, 50, to);
      checks++; if (acc_cnt - base != 2*W) begin errors++; $display("FAIL signed_accepts: got %0d expected %0d", acc_cnt - base, 2*W); end
      checks++; if (got_q.size() - got0 != W/2) begin errors++; $display("FAIL signed_count: got %0d expected %0d", got_q.size() - got0, W/2); end
      if (got_q.size() - got0 >= 2) begin
         checks++; if (got_q[got0][0 +: 16] !== 16'hFFFD) begin errors++; $display("FAIL signed_lane0: got %h expected fffd", got_q[got0][0 +: 16]); end
         checks++; if (got_q[got0][16 +: 16] !== 16'h7FFF) begin errors++; $display("FAIL signed_lane1: got %h expected 7fff", got_q[got0][16 +: 16]); end
         checks++; if (got_q[got0][32 +: 16] !== 16'h0003) begin errors++; $display("FAIL signed_lane2: got %h expected 0003", got_q[got0][32 +: 16]); end
         checks++; if (got_q[got0][95:48] !== 48'h0) begin errors++; $display("FAIL signed_upper_lanes: got %h expected 0", got_q[got0][95:48]); end
         checks++; if (got_q[got0+1] !== 96'h0) begin errors++; $display("FAIL signed_zero_window: got %h expected 0", got_q[got0+1]); end
      end
      $display("test_signed_compare done");
   endtask

   task automatic test_latency();
      apply_reset();
      dout_ready = 1'b0;
      for (int pos = 0; pos < W + 1; pos++) begin
         @(negedge clk);
         din = ramp_px(pos);
         din_valid = 1'b1;
      end
      @(negedge clk);
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL latency_before: got %b expected 0", dout_valid); end
      din = ramp_px(W + 1);
      din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL latency_cycle1: got %b expected 0", dout_valid); end
      @(negedge clk);
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL latency_cycle2: got %b expected 1", dout_valid); end
      checks++; if (dout !== exp_out(0)) begin errors++; $display("FAIL latency_dout: got %h expected %h", dout, exp_out(0)); end
      @(negedge clk);
      checks++; if (dout_valid !== 1'b1 || dout !== exp_out(0)) begin errors++; $display("FAIL latency_hold: got %b/%h expected 1/%h", dout_valid, dout, exp_out(0)); end
      $display("test_latency done");
   endtask

   task automatic test_backpressure();
      int got0, fd0, base, pre;
      bit to;
      apply_reset();
      got0 = got_q.size();
      fd0  = fd_cnt;
      base = acc_cnt;
      stream(0, NPX, 100, 0, 300, to);
      pre = acc_cnt - base;
      checks++; if (to !== 1'b1) begin errors++; $display("FAIL bp_stall: got %b expected 1", to); end
      checks++; if (pre != 78) begin errors++; $display("FAIL bp_accepted: got %0d expected 78", pre); end
      checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL bp_din_ready: got %b expected 0", din_ready); end
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL bp_dout_valid: got %b expected 1", dout_valid); end
      checks++; if (dout !== exp_out(0)) begin errors++; $display("FAIL bp_head: got %h expected %h", dout, exp_out(0)); end
      checks++; if (got_q.size() != got0) begin errors++; $display("FAIL bp_no_pop: got %0d expected 0", got_q.size() - got0); end
      stream(pre, NPX - pre, 100, 100, 2000, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_resume_timeout: got %b expected 0", to); end
      dout_ready = 1'b1;
      wait_outputs(got0 + NOUT, 200, to);
      repeat (5) @(negedge clk);
      checks++; if (got_q.size() - got0 != NOUT) begin errors++; $display("FAIL bp_count: got %0d expected %0d", got_q.size() - got0, NOUT); end
      for (int p = 0; p < NOUT && got0 + p < got_q.size(); p++) begin
         checks++;
         if (got_q[got0+p] !== exp_out(p)) begin
            errors++; $display("FAIL bp_out[%0d]: got %h expected %h", p, got_q[got0+p], exp_out(p));
         end
      end
      checks++; if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL bp_frame_done: got %0d expected 1", fd_cnt - fd0); end
      $display("test_backpressure done: stalled after %0d pixels", pre);
   endtask

   task automatic test_reset_mid_frame();
      int got0, fd0, base;
      bit to;
      apply_reset();
      got0 = got_q.size();
      base = acc_cnt;
      stream(0, 150, 100, 100, 400, to);
      stream(150, 28, 100, 0, 100, to);
      repeat (4) @(negedge clk);
      checks++; if (acc_cnt - base != 178) begin errors++; $display("FAIL mid_accepted: got %0d expected 178", acc_cnt - base); end
      checks++; if (got_q.size() - got0 != 36) begin errors++; $display("FAIL mid_drained: got %0d expected 36", got_q.size() - got0); end
      checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL mid_holding: got %b expected 1", dout_valid); end
      rst_n = 1'b0;
      #1;
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_dout_valid: got %b expected 0", dout_valid); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL mid_reset_frame_done: got %b expected 0", frame_done); end
      checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_din_ready: got %b expected 1", din_ready); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      got0 = got_q.size();
      fd0  = fd_cnt;
      stream(0, NPX, 100, 100, 2000, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL mid_frame_timeout: got %b expected 0", to); end
      dout_ready = 1'b1;
      wait_outputs(got0 + NOUT, 200, to);
      repeat (5) @(negedge clk);
      checks++; if (got_q.size() - got0 != NOUT) begin errors++; $display("FAIL mid_count: got %0d expected %0d", got_q.size() - got0, NOUT); end
      for (int p = 0; p < NOUT && got0 + p < got_q.size(); p++) begin
         checks++;
         if (got_q[got0+p] !== exp_out(p)) begin
            errors++; $display("FAIL mid_out[%0d]: got %h expected %h", p, got_q[got0+p], exp_out(p));
         end
      end
      checks++; if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL mid_frame_done: got %0d expected 1", fd_cnt - fd0); end
      $display("test_reset_mid_frame done");
   endtask

   task automatic test_back_to_back();
      int got0, fd0;
      bit to;
      apply_reset();
      got0 = got_q.size();
      fd0  = fd_cnt;
      stream(0, 2*NPX, 70, 70, 8000, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL b2b_input_timeout: got %b expected 0", to); end
      dout_ready = 1'b1;
      wait_outputs(got0 + 2*NOUT, 1000, to);
      repeat (5) @(negedge clk);
      checks++; if (got_q.size() - got0 != 2*NOUT) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size() - got0, 2*NOUT); end
      for (int p = 0; p < 2*NOUT && got0 + p < got_q.size(); p++) begin
         checks++;
         if (got_q[got0+p] !== exp_out(p % NOUT)) begin
            errors++; $display("FAIL b2b_out[%0d]: got %h expected %h", p, got_q[got0+p], exp_out(p % NOUT));
         end
      end
      checks++; if (fd_cnt - fd0 != 2) begin errors++; $display("FAIL b2b_frame_done: got %0d expected 2", fd_cnt - fd0); end
      $display("test_back_to_back done: %0d outputs", got_q.size() - got0);
   endtask

   initial begin
      test_reset();
      test_ramp_frame();
      test_signed_compare();
      test_latency();
      test_backpressure();
      test_reset_mid_frame();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
